// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
package uart_defs;

  // Parity selection; 2'b11 is not a member and is treated as no parity.
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Bit-period-minus-one divisors for a 50 MHz mclk.
  localparam int unsigned BAUD_DIV_9600   = 5207;
  localparam int unsigned BAUD_DIV_115200 = 433;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered flags and level.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign level   = level_q;

  // Pointer and occupancy update; flags are derived from the next level so they stay registered.
  always_comb begin
    do_push  = wr_en && !full_q;
    do_pop   = rd_en && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == DEPTH[AW:0]);
    empty_d = (level_d == '0);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from a small FIFO, with runtime parity, stop bits and baud divisor.
module uart_tx_fifo
  import uart_defs::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned FIFO_AW   = 2,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DIV_W-1:0]     div_set,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 busy,
  output logic                 tx_done,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 tx
);

  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 push, pop;
  logic                 bit_end;

  tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     timer_q, timer_d;
  logic [DIV_W-1:0]     div_lat_q, div_lat_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  assign push    = s_valid && !fifo_full;
  assign s_ready = !fifo_full;
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .AW   (FIFO_AW)
  ) u_fifo (
    .clk    (mclk),
    .rst    (rst),
    .wr_en  (push),
    .wr_data(s_data),
    .rd_en  (pop),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Next-state logic for the framer: bit timer, bit counter, shifter, parity and line value.
  always_comb begin
    state_d    = state_q;
    div_lat_d  = div_lat_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    pmode_d    = pmode_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    bit_end    = (timer_q == div_lat_q);
    timer_d    = bit_end ? '0 : timer_q + 1'b1;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!fifo_empty) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          par_d = par_q ^ shift_q[0];
          if (bit_cnt_q == BIT_LAST) begin
            stop_cnt_d = 1'b0;
            if (pmode_q == PAR_EVEN || pmode_q == PAR_ODD) begin
              state_d = PARITY;
              tx_d    = (pmode_q == PAR_ODD) ? ~par_d : par_d;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Shared frame load for both the idle start and the back-to-back start out of STOP.
    if (pop) begin
      state_d    = START;
      shift_d    = fifo_rd_data;
      div_lat_d  = div_set;
      pmode_d    = parity_mode;
      stop2_d    = stop2;
      timer_d    = '0;
      bit_cnt_d  = '0;
      par_d      = 1'b0;
      stop_cnt_d = 1'b0;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end
  end

  // Framer registers; reset drops any frame in flight and idles the line high.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      div_lat_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      pmode_q    <= '0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_lat_q  <= div_lat_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      pmode_q    <= pmode_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8-bit and 5-bit instances, frame table plus corner sequences.
module tb_uart_tx_fifo;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic        rst;

  logic [7:0]  s_data8;
  logic        s_valid8, s_ready8, st8, busy8, done8, tx8;
  logic [15:0] div8;
  logic [1:0]  pm8;
  logic [2:0]  lvl8;

  logic [4:0]  s_data5;
  logic        s_valid5, s_ready5, st5, busy5, done5, tx5;
  logic [15:0] div5;
  logic [1:0]  pm5;
  logic [2:0]  lvl5;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_AW(2), .DIV_W(16)) dut8 (
    .mclk(mclk), .rst(rst), .s_data(s_data8), .s_valid(s_valid8), .s_ready(s_ready8),
    .div_set(div8), .parity_mode(pm8), .stop2(st8), .busy(busy8), .tx_done(done8),
    .fifo_level(lvl8), .tx(tx8)
  );

  uart_tx_fifo #(.DATA_BITS(5), .FIFO_AW(2), .DIV_W(16)) dut5 (
    .mclk(mclk), .rst(rst), .s_data(s_data5), .s_valid(s_valid5), .s_ready(s_ready5),
    .div_set(div5), .parity_mode(pm5), .stop2(st5), .busy(busy5), .tx_done(done5),
    .fifo_level(lvl5), .tx(tx5)
  );

  typedef struct {
    bit          sel5;
    logic [7:0]  data;
    logic [1:0]  pmode;
    logic        stop2;
    logic [15:0] div;
    logic [11:0] bits;  // frame bit i at position i, start bit at 0
    int          len;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic tx_s(input bit s);
    return s ? tx5 : tx8;
  endfunction
  function automatic logic done_s(input bit s);
    return s ? done5 : done8;
  endfunction
  function automatic logic busy_s(input bit s);
    return s ? busy5 : busy8;
  endfunction
  function automatic int lvl_s(input bit s);
    return s ? int'(lvl5) : int'(lvl8);
  endfunction

  task automatic run_frame(input vec_t v, input int id);
    int n, c, errs, idx, per;
    per = int'(v.div) + 1;
    @(negedge mclk);
    if (v.sel5) begin
      s_data5 = v.data[4:0]; div5 = v.div; pm5 = v.pmode; st5 = v.stop2; s_valid5 = 1'b1;
    end else begin
      s_data8 = v.data; div8 = v.div; pm8 = v.pmode; st8 = v.stop2; s_valid8 = 1'b1;
    end
    @(posedge mclk);
    @(negedge mclk);
    s_valid5 = 1'b0;
    s_valid8 = 1'b0;
    check($sformatf("v%0d_level", id), lvl_s(v.sel5), 1);
    n = 0;
    while (tx_s(v.sel5) !== 1'b0 && n < 10) begin
      @(negedge mclk);
      n++;
    end
    check($sformatf("v%0d_latency", id), n, 1);
    c = 0;
    errs = 0;
    while (done_s(v.sel5) !== 1'b1 && c < 400) begin
      idx = c / per;
      if (idx < 12) begin
        if (tx_s(v.sel5) !== v.bits[idx]) errs++;
      end else begin
        errs++;
      end
      if (busy_s(v.sel5) !== 1'b1) errs++;
      @(negedge mclk);
      c++;
    end
    check($sformatf("v%0d_len", id), c, v.len);
    check($sformatf("v%0d_bits", id), errs, 0);
    check($sformatf("v%0d_busy_end", id), int'(busy_s(v.sel5)), 0);
    check($sformatf("v%0d_tx_end", id), int'(tx_s(v.sel5)), 1);
    @(negedge mclk);
    check($sformatf("v%0d_done_pulse", id), int'(done_s(v.sel5)), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d [6];
    int acc [6];
    logic txw [136];
    logic dnw [136];
    logic bsw [136];
    int idx, errs, c, c2, b;
    bit hs;
    logic exp_bit;

    vecs[0] = '{1'b0, 8'hA5, 2'b00, 1'b0, 16'd3, 12'h34A, 40};
    vecs[1] = '{1'b0, 8'h07, 2'b01, 1'b0, 16'd0, 12'h60E, 11};
    vecs[2] = '{1'b0, 8'h07, 2'b10, 1'b0, 16'd0, 12'h40E, 11};
    vecs[3] = '{1'b0, 8'h07, 2'b01, 1'b1, 16'd0, 12'hE0E, 12};
    vecs[4] = '{1'b0, 8'h00, 2'b00, 1'b1, 16'd1, 12'h600, 22};
    vecs[5] = '{1'b0, 8'hFF, 2'b10, 1'b0, 16'd2, 12'h7FE, 33};
    vecs[6] = '{1'b0, 8'h81, 2'b11, 1'b0, 16'd0, 12'h302, 10};
    vecs[7] = '{1'b1, 8'h1F, 2'b10, 1'b0, 16'd0, 12'h0BE, 8};
    vecs[8] = '{1'b1, 8'h13, 2'b01, 1'b1, 16'd1, 12'h1E6, 18};

    rst = 1'b1;
    s_data8 = '0; s_valid8 = 1'b0; div8 = 16'd3; pm8 = 2'b00; st8 = 1'b0;
    s_data5 = '0; s_valid5 = 1'b0; div5 = 16'd0; pm5 = 2'b00; st5 = 1'b0;
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    rst = 1'b0;
    check("rst_tx", int'(tx8), 1);
    check("rst_busy", int'(busy8), 0);
    check("rst_done", int'(done8), 0);
    check("rst_ready", int'(s_ready8), 1);
    check("rst_level", int'(lvl8), 0);
    check("rst_tx5", int'(tx5), 1);

    for (int i = 0; i < 9; i++) run_frame(vecs[i], i);

    // Fill: div 1, 8N1, six bytes offered back to back.
    d[0] = 8'h11; d[1] = 8'h2E; d[2] = 8'hC3; d[3] = 8'h5A; d[4] = 8'hF0; d[5] = 8'h96;
    for (int i = 0; i < 6; i++) acc[i] = -1;
    @(negedge mclk);
    div8 = 16'd1; pm8 = 2'b00; st8 = 1'b0;
    idx = 0;
    s_data8 = d[0];
    s_valid8 = 1'b1;
    hs = s_ready8;
    for (int k = 1; k <= 135; k++) begin
      @(posedge mclk);
      @(negedge mclk);
      if (hs) begin
        if (idx < 6) acc[idx] = k;
        idx++;
        if (idx < 6) s_data8 = d[idx];
        else s_valid8 = 1'b0;
      end
      hs = s_valid8 && s_ready8;
      txw[k] = tx8;
      dnw[k] = done8;
      bsw[k] = busy8;
      if (k == 2) check("fill_push_pop_level", int'(lvl8), 1);
      if (k == 5) begin
        check("fill_ready_full", int'(s_ready8), 0);
        check("fill_level_full", int'(lvl8), 4);
      end
    end
    s_valid8 = 1'b0;
    check("fill_acc0", acc[0], 1);
    check("fill_acc1", acc[1], 2);
    check("fill_acc4", acc[4], 5);
    check("fill_acc5", acc[5], 23);
    for (int f = 0; f < 6; f++) begin
      errs = 0;
      for (int j = 0; j < 20; j++) begin
        b = j / 2;
        if (b == 0) exp_bit = 1'b0;
        else if (b <= 8) exp_bit = d[f][b-1];
        else exp_bit = 1'b1;
        if (txw[2 + 20*f + j] !== exp_bit) errs++;
      end
      check($sformatf("fill_frame%0d", f), errs, 0);
    end
    errs = 0;
    for (int k = 1; k <= 135; k++) begin
      if (dnw[k] !== ((k >= 22 && k <= 122 && (k - 2) % 20 == 0) ? 1'b1 : 1'b0)) errs++;
      if (bsw[k] !== ((k >= 2 && k <= 121) ? 1'b1 : 1'b0)) errs++;
    end
    check("fill_done_busy", errs, 0);

    // Divisor change mid-frame only affects the following frame.
    @(negedge mclk);
    div8 = 16'd3; s_data8 = 8'h3C; s_valid8 = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    s_data8 = 8'hC3;
    @(posedge mclk);
    @(negedge mclk);
    s_valid8 = 1'b0;
    check("div_push_pop_level", int'(lvl8), 1);
    check("div_first_low", int'(tx8), 0);
    c = 0;
    while (done8 !== 1'b1 && c < 200) begin
      if (c == 10) div8 = 16'd9;
      @(negedge mclk);
      c++;
    end
    check("div_frame1_len", c, 40);
    check("div_b2b_busy", int'(busy8), 1);
    check("div_b2b_start", int'(tx8), 0);
    c2 = 0;
    do begin
      @(negedge mclk);
      c2++;
    end while (done8 !== 1'b1 && c2 < 300);
    check("div_frame2_len", c2, 100);
    @(negedge mclk);
    div8 = 16'd3;

    // Reset during data bit 4 with two bytes queued.
    s_data8 = 8'h5A; s_valid8 = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    s_data8 = 8'h66;
    @(posedge mclk);
    @(negedge mclk);
    s_data8 = 8'h77;
    @(posedge mclk);
    @(negedge mclk);
    s_valid8 = 1'b0;
    check("rstmid_level_q", int'(lvl8), 2);
    repeat (20) @(negedge mclk);
    check("rstmid_busy_pre", int'(busy8), 1);
    rst = 1'b1;
    @(negedge mclk);
    rst = 1'b0;
    check("rstmid_tx", int'(tx8), 1);
    check("rstmid_level", int'(lvl8), 0);
    check("rstmid_busy", int'(busy8), 0);
    check("rstmid_ready", int'(s_ready8), 1);
    errs = 0;
    if (done8 !== 1'b0) errs++;
    repeat (120) begin
      @(negedge mclk);
      if (tx8 !== 1'b1 || done8 !== 1'b0 || busy8 !== 1'b0 || lvl8 !== 3'd0) errs++;
    end
    check("rstmid_quiet", errs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO. It succeeds the fixed 8N1 byte transmitter with:
- configurable data width and FIFO depth;
- runtime parity mode, stop-bit count and baud divisor;
- a valid/ready input handshake that allows back-to-back frames with no idle gap.

It sits between any byte producer (image streamer, debug logger) and the board RS-232 pin.

## Interface
Parameters:
- DATA_BITS, 8, character width, legal 5..8
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW
- DIV_W, 16, width of baud divisor input

Ports:
- mclk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- s_data  in  DATA_BITS  character to send
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept; equals !full
- div_set  in  DIV_W  bit period minus one, in mclk cycles
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- stop2  in  1  0 = one stop bit, 1 = two stop bits
- busy  out  1  frame in progress
- tx_done  out  1  one-cycle pulse at end of each frame
- fifo_level  out  FIFO_AW+1  entries currently stored
- tx  out  1  serial line, idle high

## Operation
- Push: when s_valid && s_ready at a rising edge, s_data is written to the FIFO.
  - s_ready depends only on the full flag; there is no combinational path from s_valid.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START: FIFO non-empty.
    - In that cycle (the pop cycle) the FSM pops one entry into a shift register.
    - It also latches div_set, parity_mode and stop2 into frame registers.
    - Later changes to these inputs have no effect until the next pop.
  - START -> DATA: after one bit period, tx = 0.
  - DATA: DATA_BITS bit periods, LSB first; the shift register shifts right once per bit.
    - Exits to PARITY if the latched mode is even or odd, else to STOP.
  - PARITY: one bit period.
    - even: tx = XOR of data bits.
    - odd: tx = inverted XOR of data bits.
  - STOP: one or two bit periods, tx = 1.
    - At the last cycle: if the FIFO is non-empty, pop and go to START (no idle gap); else go to IDLE.
- Bit timer: counts 0..div_lat, then reloads; bit period = div_lat+1 cycles. div_set = 0 gives one cycle per bit.
- Frame length: (1 + DATA_BITS + P + S) × (div_lat+1) cycles, where P ∈ {0,1} (parity bit present) and S ∈ {1,2} (stop bits).

## Timing
Reset values:
- tx = 1, busy = 0, tx_done = 0
- s_ready = 1, fifo_level = 0
- FSM in IDLE, FIFO emptied

Latency and framing:
- All outputs are registered.
- A push at edge N into an empty idle block sets fifo_level = 1 after N and pops at edge N+1.
- tx goes low and busy goes high after edge N+1.
- tx_done is high for exactly one cycle: the cycle following the final stop-bit cycle. busy falls in that same cycle unless a back-to-back frame started.

Boundary conditions:
- Simultaneous push and pop: fifo_level unchanged.
- Full FIFO: s_ready = 0; a held s_valid is accepted the cycle after the next pop frees an entry.
- FIFO pointers wrap modulo depth; fifo_level saturates at no value, since overflow is impossible by construction.
- rst asserted mid-frame: the next edge forces tx = 1 and the FSM to IDLE and clears the FIFO. The in-flight character and queued data are discarded, and no tx_done is produced.
- DATA_BITS < 8: only the low DATA_BITS of s_data are stored and sent.

## Structure
- Shared package uart_defs:
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - FSM state encoding;
  - legal baud divisor constants for 50 MHz (9600: 5207, 115200: 433).
- Sub-module sync_fifo, parameters WIDTH and AW:
  - single clock, synchronous active-high reset;
  - registered full/empty and level;
  - read data valid in the cycle of the pop strobe (first-word fall-through).
- Top level: FSM, bit timer, bit counter, shift register, parity accumulator, output register.

## Test plan
- 8N1, div_set=3, push 0xA5.
  - tx = 0 | 1,0,1,0,0,1,0,1 | 1, 4 cycles per bit.
  - 40 cycles from first low to tx_done; busy low afterwards.
- Parity on 0x07 (DATA_BITS=8, div_set=0):
  - even: parity bit 1; odd: parity bit 0.
  - Frame 11 cycles; stop2=1 gives 12 cycles.
- FIFO_AW=2, div_set=1, push 6 bytes on consecutive cycles.
  - Five accepted, then s_ready=0; sixth accepted the cycle after the second pop.
  - Frames follow with no idle-high gap between stop and start.
- Change div_set from 3 to 9 mid-frame.
  - Current frame keeps 4-cycle bits; next frame uses 10-cycle bits.
- Assert rst during DATA bit 4 with 2 bytes queued.
  - tx = 1 next cycle, fifo_level = 0, no tx_done, no further frames.
- DATA_BITS=5, push 0x1F with odd parity.
  - tx = 0 | 1,1,1,1,1 | 0 | 1 (odd parity bit 0, since five ones is already odd).
